cpu_clock_ctrl: RTL and testbench

Parametrised clock-control block for the processor top level. It is the successor of the fixed divide-by-two toggle.
- Generates a one-cycle CPU clock-enable from the board clock with a runtime divide ratio.
- Adds halt, micro-cycle step, instruction step and PC breakpoints (up to NUM_BP).
- Sits between the top-level pins and the Multiciclo core, which advances one state per enable pulse.

---
 rtl/clk_ctrl_pkg.sv | 20 ++
 rtl/cpu_clock_ctrl_bp_match.sv | 30 +++
 rtl/cpu_clock_ctrl.sv | 145 ++++++++++++++
 tb/tb_cpu_clock_ctrl.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_ctrl_pkg.sv
// Shared types for the CPU clock-control block.
// Mode pin encoding, controller states and default fetch-state code.
package clk_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_RUN    = 2'b00,
    MODE_STEP   = 2'b01,
    MODE_RUN_BP = 2'b10,
    MODE_HALT   = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  localparam logic [3:0] FETCH_STATE_DEF = 4'd0;

endpackage

// File: rtl/cpu_clock_ctrl_bp_match.sv
// PC breakpoint comparators, qualified by the core being at fetch.
// Purely combinational; hit_o flags every enabled slot that matches.
module bp_match #(
  parameter int unsigned PC_W   = 32,
  parameter int unsigned NUM_BP = 2
) (
  input  logic [PC_W-1:0]        pc_i,
  input  logic [NUM_BP*PC_W-1:0] bp_addr_i,
  input  logic [NUM_BP-1:0]      bp_en_i,
  input  logic [3:0]             estado_i,
  input  logic [3:0]             fetch_state_i,
  output logic [NUM_BP-1:0]      hit_o,
  output logic                   any_o
);

  logic at_fetch;

  assign at_fetch = (estado_i == fetch_state_i);

  always_comb begin
    hit_o = '0;
    for (int i = 0; i < NUM_BP; i++) begin
      hit_o[i] = at_fetch && bp_en_i[i] &&
                 (bp_addr_i[i*PC_W +: PC_W] == pc_i);
    end
  end

  assign any_o = |hit_o;

endmodule

// File: rtl/cpu_clock_ctrl.sv
// CPU clock-enable generator with runtime divider, halt, micro/instruction
// step and PC breakpoints for the Multiciclo core.
import clk_ctrl_pkg::*;

module cpu_clock_ctrl #(
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned PC_W        = 32,
  parameter int unsigned NUM_BP      = 2,
  parameter logic [3:0]  FETCH_STATE = FETCH_STATE_DEF
) (
  input  logic                   CLOCK,
  input  logic                   Reset,
  input  logic [1:0]             Mode,
  input  logic                   StepUnit,
  input  logic                   StepBtn,
  input  logic [DIV_W-1:0]       DivRatio,
  input  logic [NUM_BP*PC_W-1:0] BpAddr,
  input  logic [NUM_BP-1:0]      BpEn,
  input  logic [PC_W-1:0]        PC,
  input  logic [3:0]             Estado,
  output logic                   ClockEn,
  output logic                   ClockDIV,
  output logic                   Halted,
  output logic [NUM_BP-1:0]      BpHit,
  output logic [31:0]            TickCount
);

  mode_t              mode;
  state_t             state_q, state_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic               step_q;
  logic               issued_q, issued_d;
  logic               clken_q, pulse;
  logic               clkdiv_q;
  logic [NUM_BP-1:0]  bphit_q, bphit_d;
  logic [31:0]        tick_q;
  logic [NUM_BP-1:0]  hit;
  logic               any_hit;
  logic               tick;
  logic               step_edge;
  logic               at_fetch;

  assign mode      = mode_t'(Mode);
  assign step_edge = StepBtn & ~step_q;
  assign at_fetch  = (Estado == FETCH_STATE);
  assign tick      = (state_q != ST_HALT) && (cnt_q >= DivRatio);

  bp_match #(
    .PC_W   (PC_W),
    .NUM_BP (NUM_BP)
  ) u_bp_match (
    .pc_i          (PC),
    .bp_addr_i     (BpAddr),
    .bp_en_i       (BpEn),
    .estado_i      (Estado),
    .fetch_state_i (FETCH_STATE),
    .hit_o         (hit),
    .any_o         (any_hit)
  );

  always_comb begin
    state_d  = state_q;
    bphit_d  = bphit_q;
    issued_d = issued_q;
    pulse    = 1'b0;
    unique case (state_q)
      ST_HALT: begin
        if (mode == MODE_RUN || mode == MODE_RUN_BP) begin
          state_d  = ST_RUN;
          bphit_d  = '0;
          issued_d = 1'b0;
        end else if (mode == MODE_STEP && step_edge) begin
          state_d  = ST_STEP;
          bphit_d  = '0;
          issued_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (mode == MODE_HALT || mode == MODE_STEP) begin
          state_d = ST_HALT;
        end else if (tick) begin
          // issued gates the match so a resume at the bp address proceeds
          if (mode == MODE_RUN_BP && any_hit && issued_q) begin
            state_d = ST_HALT;
            bphit_d = hit;
          end else begin
            pulse = 1'b1;
          end
        end
      end
      ST_STEP: begin
        if (mode == MODE_HALT) begin
          state_d = ST_HALT;
        end else if (tick) begin
          if (!StepUnit) begin
            pulse   = 1'b1;
            state_d = ST_HALT;
          end else if (issued_q && at_fetch) begin
            state_d = ST_HALT;
          end else begin
            pulse = 1'b1;
          end
        end
      end
      default: state_d = ST_HALT;
    endcase
    if (pulse) issued_d = 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (state_q == ST_HALT || tick) cnt_d = '0;
  end

  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      state_q  <= ST_HALT;
      cnt_q    <= '0;
      step_q   <= 1'b0;
      issued_q <= 1'b0;
      clken_q  <= 1'b0;
      clkdiv_q <= 1'b1;
      bphit_q  <= '0;
      tick_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      step_q   <= StepBtn;
      issued_q <= issued_d;
      clken_q  <= pulse;
      bphit_q  <= bphit_d;
      if (pulse) begin
        clkdiv_q <= ~clkdiv_q;
        tick_q   <= tick_q + 32'd1;
      end
    end
  end

  assign ClockEn   = clken_q;
  assign ClockDIV  = clkdiv_q;
  assign Halted    = (state_q == ST_HALT);
  assign BpHit     = bphit_q;
  assign TickCount = tick_q;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Self-checking bench for cpu_clock_ctrl with a small Multiciclo core model.
// Expected pulse times are derived arithmetically from entry edges and ratios.
import clk_ctrl_pkg::*;

module tb_cpu_clock_ctrl;

  logic        CLOCK = 1'b0;
  logic        Reset;
  logic [1:0]  Mode;
  logic        StepUnit;
  logic        StepBtn;
  logic [7:0]  DivRatio;
  logic [63:0] BpAddr;
  logic [1:0]  BpEn;
  logic [31:0] PC;
  logic [3:0]  Estado;
  logic        ClockEn;
  logic        ClockDIV;
  logic        Halted;
  logic [1:0]  BpHit;
  logic [31:0] TickCount;

  cpu_clock_ctrl #(
    .DIV_W       (8),
    .PC_W        (32),
    .NUM_BP      (2),
    .FETCH_STATE (4'd0)
  ) dut (
    .CLOCK     (CLOCK),
    .Reset     (Reset),
    .Mode      (Mode),
    .StepUnit  (StepUnit),
    .StepBtn   (StepBtn),
    .DivRatio  (DivRatio),
    .BpAddr    (BpAddr),
    .BpEn      (BpEn),
    .PC        (PC),
    .Estado    (Estado),
    .ClockEn   (ClockEn),
    .ClockDIV  (ClockDIV),
    .Halted    (Halted),
    .BpHit     (BpHit),
    .TickCount (TickCount)
  );

  always #5 CLOCK = ~CLOCK;

  int cyc = 0;
  always @(posedge CLOCK) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  logic [31:0] exp_ticks;
  logic        exp_div;

  // core model: fetch(0) -> 1 -> 2 -> fetch, PC += 4 per instruction
  logic        core_en  = 1'b0;
  logic        core_rst = 1'b1;
  logic [3:0]  est_m    = 4'd0;
  logic [31:0] pc_m     = 32'd0;

  always @(posedge CLOCK) begin
    #1;
    if (core_rst) begin
      est_m = 4'd0;
      pc_m  = 32'd0;
    end else if (core_en && ClockEn) begin
      if (est_m == 4'd2) begin
        est_m = 4'd0;
        pc_m  = pc_m + 32'd4;
      end else begin
        est_m = est_m + 4'd1;
      end
    end
  end

  assign Estado = est_m;
  assign PC     = pc_m;

  task automatic do_reset();
    @(negedge CLOCK);
    Reset    = 1'b1;
    Mode     = MODE_HALT;
    StepBtn  = 1'b0;
    core_rst = 1'b1;
    core_en  = 1'b0;
    @(negedge CLOCK);
    Reset     = 1'b0;
    exp_ticks = 32'd0;
    exp_div   = 1'b1;
    @(negedge CLOCK);
    core_rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (ClockEn !== 1'b0) $display("FAIL reset_clken got %b want 0", ClockEn);
    else passes++;
    checks++;
    if (ClockDIV !== 1'b1) $display("FAIL reset_clkdiv got %b want 1", ClockDIV);
    else passes++;
    checks++;
    if (Halted !== 1'b1) $display("FAIL reset_halted got %b want 1", Halted);
    else passes++;
    checks++;
    if (BpHit !== 2'b00) $display("FAIL reset_bphit got %b want 00", BpHit);
    else passes++;
    checks++;
    if (TickCount !== 32'd0) $display("FAIL reset_ticks got %0d want 0", TickCount);
    else passes++;
  endtask

  task automatic test_run(input int d, input int len);
    int   e0, j;
    logic exp_en;
    @(negedge CLOCK);
    DivRatio = 8'(d);
    Mode     = MODE_RUN;
    e0       = cyc + 1;
    for (int k = 0; k < len; k++) begin
      @(negedge CLOCK);
      j      = cyc - e0;
      exp_en = (j >= d + 1) && (((j - d - 1) % (d + 1)) == 0);
      if (exp_en) begin
        exp_ticks = exp_ticks + 32'd1;
        exp_div   = ~exp_div;
      end
      checks++;
      if (ClockEn !== exp_en)
        $display("FAIL run_clken d=%0d j=%0d got %b want %b", d, j, ClockEn, exp_en);
      else passes++;
      checks++;
      if (ClockDIV !== exp_div)
        $display("FAIL run_clkdiv d=%0d j=%0d got %b want %b", d, j, ClockDIV, exp_div);
      else passes++;
      checks++;
      if (TickCount !== exp_ticks)
        $display("FAIL run_ticks d=%0d j=%0d got %0d want %0d", d, j, TickCount, exp_ticks);
      else passes++;
      checks++;
      if (Halted !== 1'b0)
        $display("FAIL run_halted d=%0d j=%0d got %b want 0", d, j, Halted);
      else passes++;
    end
    Mode = MODE_HALT;
    @(negedge CLOCK);
    checks++;
    if (ClockEn !== 1'b0 || Halted !== 1'b1)
      $display("FAIL run_stop got en=%b halted=%b want en=0 halted=1", ClockEn, Halted);
    else passes++;
    checks++;
    if (TickCount !== exp_ticks)
      $display("FAIL run_stop_ticks got %0d want %0d", TickCount, exp_ticks);
    else passes++;
  endtask

  task automatic test_step_micro(input int d);
    int   e0, j;
    logic exp_en, exp_halt;
    @(negedge CLOCK);
    DivRatio = 8'(d);
    StepUnit = 1'b0;
    Mode     = MODE_STEP;
    StepBtn  = 1'b1;
    e0       = cyc + 1;
    for (int k = 0; k < d + 11; k++) begin
      @(negedge CLOCK);
      j        = cyc - e0;
      exp_en   = (j == d + 1);
      exp_halt = (j >= d + 1);
      if (exp_en) exp_ticks = exp_ticks + 32'd1;
      checks++;
      if (ClockEn !== exp_en)
        $display("FAIL ustep_clken d=%0d j=%0d got %b want %b", d, j, ClockEn, exp_en);
      else passes++;
      checks++;
      if (Halted !== exp_halt)
        $display("FAIL ustep_halted d=%0d j=%0d got %b want %b", d, j, Halted, exp_halt);
      else passes++;
    end
    checks++;
    if (TickCount !== exp_ticks)
      $display("FAIL ustep_ticks got %0d want %0d", TickCount, exp_ticks);
    else passes++;
    StepBtn = 1'b0;
    Mode    = MODE_HALT;
  endtask

  task automatic test_step_instr(input int d);
    int   e0, j, npulse;
    logic exp_en, exp_halt;
    do_reset();
    core_en = 1'b1;
    npulse  = 0;
    @(negedge CLOCK);
    DivRatio = 8'(d);
    StepUnit = 1'b1;
    Mode     = MODE_STEP;
    StepBtn  = 1'b1;
    e0       = cyc + 1;
    for (int k = 0; k < 4 * (d + 1) + 6; k++) begin
      @(negedge CLOCK);
      j        = cyc - e0;
      exp_en   = (j >= d + 1) && ((j % (d + 1)) == 0) && ((j / (d + 1)) <= 3);
      exp_halt = (j >= 4 * (d + 1));
      if (ClockEn === 1'b1) npulse++;
      checks++;
      if (ClockEn !== exp_en)
        $display("FAIL istep_clken d=%0d j=%0d got %b want %b", d, j, ClockEn, exp_en);
      else passes++;
      checks++;
      if (Halted !== exp_halt)
        $display("FAIL istep_halted d=%0d j=%0d got %b want %b", d, j, Halted, exp_halt);
      else passes++;
    end
    checks++;
    if (npulse != 3) $display("FAIL istep_pulses got %0d want 3", npulse);
    else passes++;
    checks++;
    if (Estado !== 4'd0) $display("FAIL istep_estado got %0d want 0", Estado);
    else passes++;
    checks++;
    if (TickCount !== 32'd3) $display("FAIL istep_ticks got %0d want 3", TickCount);
    else passes++;
    StepBtn = 1'b0;
    Mode    = MODE_HALT;
    core_en = 1'b0;
  endtask

  task automatic test_breakpoint(input logic [31:0] a0, input logic [31:0] a1,
                                 input logic [1:0] en, input int d);
    logic [31:0] s;
    logic [1:0]  exp_hit;
    int          bound;
    bit          seen;
    do_reset();
    s = 32'hFFFF_FFFF;
    if (en[0] && a0 < s) s = a0;
    if (en[1] && a1 < s) s = a1;
    exp_hit = {en[1] && (a1 == s), en[0] && (a0 == s)};
    core_en = 1'b1;
    BpAddr  = {a1, a0};
    BpEn    = en;
    bound   = (int'(s) / 4 * 3 + 3) * (d + 1) + 20;
    seen    = 1'b0;
    @(negedge CLOCK);
    DivRatio = 8'(d);
    Mode     = MODE_RUN_BP;
    @(negedge CLOCK);
    for (int k = 0; k < bound && !seen; k++) begin
      @(negedge CLOCK);
      if (Halted === 1'b1) begin
        Mode = MODE_HALT;
        seen = 1'b1;
      end
    end
    checks++;
    if (!seen) $display("FAIL bp_timeout s=%0h got running want halted", s);
    else passes++;
    checks++;
    if (BpHit !== exp_hit) $display("FAIL bp_hit s=%0h got %b want %b", s, BpHit, exp_hit);
    else passes++;
    checks++;
    if (PC !== s) $display("FAIL bp_pc got %0h want %0h", PC, s);
    else passes++;
    checks++;
    if (Estado !== 4'd0 || ClockEn !== 1'b0)
      $display("FAIL bp_stop got estado=%0d en=%b want 0 0", Estado, ClockEn);
    else passes++;
    checks++;
    if (TickCount !== s / 4 * 3)
      $display("FAIL bp_ticks got %0d want %0d", TickCount, s / 4 * 3);
    else passes++;
    @(negedge CLOCK);
    checks++;
    if (Halted !== 1'b1 || BpHit !== exp_hit)
      $display("FAIL bp_hold got halted=%b hit=%b want 1 %b", Halted, BpHit, exp_hit);
    else passes++;
    Mode = MODE_RUN_BP;
    @(negedge CLOCK);
    checks++;
    if (BpHit !== 2'b00 || Halted !== 1'b0)
      $display("FAIL bp_resume got hit=%b halted=%b want 00 0", BpHit, Halted);
    else passes++;
    for (int k = 0; k < 4 * (d + 1) + 2; k++) @(negedge CLOCK);
    Mode = MODE_HALT;
    @(negedge CLOCK);
    checks++;
    if (!(PC > s)) $display("FAIL bp_past got pc=%0h want above %0h", PC, s);
    else passes++;
    core_en = 1'b0;
  endtask

  task automatic test_div_change(input int kc, input int nd);
    int   e0, j;
    logic exp_en;
    do_reset();
    @(negedge CLOCK);
    DivRatio = 8'd200;
    Mode     = MODE_RUN;
    e0       = cyc + 1;
    for (int k = 0; k <= kc + 3 * (nd + 1) + 4; k++) begin
      @(negedge CLOCK);
      j      = cyc - e0;
      exp_en = (j >= kc + 1) && (((j - kc - 1) % (nd + 1)) == 0);
      checks++;
      if (ClockEn !== exp_en)
        $display("FAIL divchg_clken kc=%0d nd=%0d j=%0d got %b want %b",
                 kc, nd, j, ClockEn, exp_en);
      else passes++;
      if (j == kc) DivRatio = 8'(nd);
    end
    Mode = MODE_HALT;
    @(negedge CLOCK);
  endtask

  task automatic test_reset_mid(input int d);
    int e0;
    do_reset();
    @(negedge CLOCK);
    DivRatio = 8'(d);
    Mode     = MODE_RUN;
    e0       = cyc + 1;
    while (cyc < e0 + 2 * (d + 1) - 1) @(negedge CLOCK);
    checks++;
    if (TickCount !== 32'd1)
      $display("FAIL rstmid_pre got %0d want 1", TickCount);
    else passes++;
    Reset = 1'b1;
    @(negedge CLOCK);
    Reset = 1'b0;
    Mode  = MODE_HALT;
    checks++;
    if (ClockEn !== 1'b0) $display("FAIL rstmid_clken got %b want 0", ClockEn);
    else passes++;
    checks++;
    if (ClockDIV !== 1'b1 || Halted !== 1'b1 || BpHit !== 2'b00)
      $display("FAIL rstmid_outs got div=%b halted=%b hit=%b want 1 1 00",
               ClockDIV, Halted, BpHit);
    else passes++;
    checks++;
    if (TickCount !== 32'd0) $display("FAIL rstmid_ticks got %0d want 0", TickCount);
    else passes++;
    @(negedge CLOCK);
    checks++;
    if (ClockEn !== 1'b0 || Halted !== 1'b1)
      $display("FAIL rstmid_after got en=%b halted=%b want 0 1", ClockEn, Halted);
    else passes++;
  endtask

  initial begin
    logic [31:0] a0, a1;
    Reset    = 1'b1;
    Mode     = MODE_HALT;
    StepUnit = 1'b0;
    StepBtn  = 1'b0;
    DivRatio = 8'd0;
    BpAddr   = '0;
    BpEn     = 2'b00;
    exp_ticks = 32'd0;
    exp_div   = 1'b1;
    repeat (2) @(negedge CLOCK);

    test_reset();
    test_run(3, 13);
    test_run(0, 6);
    for (int i = 0; i < 3; i++)
      test_run(int'($urandom_range(0, 7)), int'($urandom_range(5, 30)));
    test_step_micro(0);
    for (int i = 0; i < 3; i++) test_step_micro(int'($urandom_range(1, 6)));
    test_step_instr(0);
    test_step_instr(int'($urandom_range(1, 3)));
    test_breakpoint(32'h10, 32'h08, 2'b01, 0);
    for (int i = 0; i < 4; i++) begin
      a0 = 32'(4 * $urandom_range(1, 8));
      a1 = 32'(4 * $urandom_range(1, 8));
      while (a1 == a0) a1 = 32'(4 * $urandom_range(1, 8));
      test_breakpoint(a0, a1, 2'($urandom_range(1, 3)), int'($urandom_range(0, 3)));
    end
    test_div_change(50, 2);
    test_div_change(int'($urandom_range(10, 150)), int'($urandom_range(0, 5)));
    test_reset_mid(int'($urandom_range(2, 6)));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
